arcade_input_ctrl: RTL and testbench

- Parametrised player-input front end for arcade cores.
- Maps packed hps_io joystick words to per-player direction, fire and start signals.
- Merged mode ORs every pad into every player; separate mode gives each player its own pad.
- Optional opposing-direction (SOCD) cleaning.
- Coin sequencer with a queue: each start press inserts a coin, then issues a timed start pulse. This replaces the old "coin = start1 | start2" wiring.

---
 rtl/arcade_input_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
//   Player-input front end for arcade cores. Maps packed hps_io joystick
//   words to per-player directions, fire buttons and start, with optional
//   opposing-direction cleaning and a queued coin/start sequencer.
//
// Ports
//   clk_sys    : system clock
//   reset      : synchronous, active-high reset
//   joy_in     : PLAYERS packed joystick words, word k at [k*JOY_W +: JOY_W]
//                (bit0 right, bit1 left, bit2 down, bit3 up)
//   merge      : 1 = every pad drives every player, 0 = one pad per player
//   auto_coin  : 1 = a start press queues a coin and defers the start
//   coin_btn   : dedicated coin buttons, active high
//   dirs_out   : per player {up,down,left,right}, registered
//   fire_out   : per player fire buttons, registered
//   start_out  : per player start
//   coin_out   : coin switch, active high
//   pending    : coins queued and not yet issued
module arcade_input_ctrl #(
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned JOY_W       = 16,
  parameter int unsigned BTN         = 1,
  parameter int unsigned START_BIT   = 5,
  parameter int unsigned SOCD        = 1,
  parameter int unsigned COIN_PULSE  = 1024,
  parameter int unsigned COIN_GAP    = 1024,
  parameter int unsigned START_PULSE = 1024
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [PLAYERS*JOY_W-1:0] joy_in,
  input  logic                     merge,
  input  logic                     auto_coin,
  input  logic [PLAYERS-1:0]       coin_btn,
  output logic [PLAYERS*4-1:0]     dirs_out,
  output logic [PLAYERS*BTN-1:0]   fire_out,
  output logic [PLAYERS-1:0]       start_out,
  output logic                     coin_out,
  output logic [2:0]               pending
);

  localparam int unsigned CNT_MAX0 = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > START_PULSE) ? CNT_MAX0 : START_PULSE;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COIN,
    S_GAP,
    S_START
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [2:0]               pending_q, pending_d;
  logic [PLAYERS-1:0]       start_req_q, start_req_d;
  logic [PLAYERS-1:0]       start_prev_q, start_prev_d;
  logic [PLAYERS-1:0]       coin_prev_q, coin_prev_d;
  logic [PLAYERS*4-1:0]     dirs_q, dirs_d;
  logic [PLAYERS*BTN-1:0]   fire_q, fire_d;
  logic [PLAYERS-1:0]       start_out_q, start_out_d;
  logic                     coin_out_q, coin_out_d;

  logic [JOY_W-1:0]         merged;
  logic [JOY_W+PLAYERS-1:0] merged_ext;
  logic [JOY_W-1:0]         word;
  logic [3:0]               dir4;
  logic [PLAYERS-1:0]       start_vec;
  logic [PLAYERS-1:0]       start_edge;
  logic [PLAYERS-1:0]       coin_edge;
  logic                     deq;
  int unsigned              e_cnt;
  int unsigned              sum;

  // Source select, direction cleaning and edge detection.
  always_comb begin
    merged     = '0;
    merged_ext = '0;
    word       = '0;
    dir4       = '0;
    start_vec  = '0;
    dirs_d     = '0;
    fire_d     = '0;
    for (int unsigned k = 0; k < PLAYERS; k++) begin
      merged = merged | joy_in[k*JOY_W +: JOY_W];
    end
    // Zero extension makes merged start indices past the word read as 0.
    merged_ext[JOY_W-1:0] = merged;
    for (int unsigned k = 0; k < PLAYERS; k++) begin
      word = merge ? merged : joy_in[k*JOY_W +: JOY_W];
      dir4 = word[3:0];
      if (SOCD != 0) begin
        if (dir4[3] && dir4[2]) dir4[3:2] = '0;
        if (dir4[1] && dir4[0]) dir4[1:0] = '0;
      end
      dirs_d[k*4 +: 4]     = dir4;
      fire_d[k*BTN +: BTN] = word[4 +: BTN];
      start_vec[k]         = merge ? merged_ext[START_BIT + k] : word[START_BIT];
    end
    start_prev_d = start_vec;
    coin_prev_d  = coin_btn;
    start_edge   = start_vec & ~start_prev_q & {PLAYERS{auto_coin}};
    coin_edge    = coin_btn & ~coin_prev_q;
  end

  // Coin/start sequencer and coin queue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    coin_out_d  = coin_out_q;
    deq         = 1'b0;
    start_req_d = start_req_q | start_edge;

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d    = S_COIN;
          cnt_d      = CNT_W'(COIN_PULSE - 1);
          coin_out_d = 1'b1;
          deq        = 1'b1;
        end
      end
      S_COIN: begin
        if (cnt_q == '0) begin
          state_d    = S_GAP;
          cnt_d      = CNT_W'(COIN_GAP - 1);
          coin_out_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (pending_q != '0) begin
            state_d    = S_COIN;
            cnt_d      = CNT_W'(COIN_PULSE - 1);
            coin_out_d = 1'b1;
            deq        = 1'b1;
          end else if (start_req_q != '0) begin
            // Requests are handed to the pulse on entry; only edges arriving
            // from here on stay queued for the next pass.
            state_d     = S_START;
            cnt_d       = CNT_W'(START_PULSE - 1);
            start_req_d = start_edge;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_START) begin
      start_out_d = (state_q == S_START) ? start_out_q : start_req_q;
    end else begin
      start_out_d = auto_coin ? '0 : start_vec;
    end

    e_cnt = 0;
    for (int unsigned k = 0; k < PLAYERS; k++) begin
      e_cnt = e_cnt + 32'(start_edge[k]) + 32'(coin_edge[k]);
    end
    sum       = 32'(pending_q) + e_cnt - (deq ? 32'd1 : 32'd0);
    pending_d = (sum > 32'd7) ? 3'd7 : sum[2:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= '0;
      start_req_q  <= '0;
      start_prev_q <= '1;
      coin_prev_q  <= '1;
      dirs_q       <= '0;
      fire_q       <= '0;
      start_out_q  <= '0;
      coin_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      start_req_q  <= start_req_d;
      start_prev_q <= start_prev_d;
      coin_prev_q  <= coin_prev_d;
      dirs_q       <= dirs_d;
      fire_q       <= fire_d;
      start_out_q  <= start_out_d;
      coin_out_q   <= coin_out_d;
    end
  end

  assign dirs_out  = dirs_q;
  assign fire_out  = fire_q;
  assign start_out = start_out_q;
  assign coin_out  = coin_out_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus randomized traffic,
// checked against a timeline-based reference model of the coin queue.
module tb_arcade_input_ctrl;
  localparam int P  = 2;
  localparam int JW = 16;
  localparam int NB = 1;
  localparam int SB = 5;
  localparam int CP = 4;
  localparam int CG = 3;
  localparam int SP = 2;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [P*JW-1:0]   joy_in;
  logic              merge;
  logic              auto_coin;
  logic [P-1:0]      coin_btn;
  logic [P*4-1:0]    dirs_out;
  logic [P*NB-1:0]   fire_out;
  logic [P-1:0]      start_out;
  logic              coin_out;
  logic [2:0]        pending;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk_sys = ~clk_sys;

  arcade_input_ctrl #(
    .PLAYERS(P), .JOY_W(JW), .BTN(NB), .START_BIT(SB), .SOCD(1),
    .COIN_PULSE(CP), .COIN_GAP(CG), .START_PULSE(SP)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .joy_in(joy_in), .merge(merge),
    .auto_coin(auto_coin), .coin_btn(coin_btn), .dirs_out(dirs_out),
    .fire_out(fire_out), .start_out(start_out), .coin_out(coin_out),
    .pending(pending)
  );

  // Reference model: coins and start pulses are scheduled as absolute
  // cycle windows; the queue is a saturating integer.
  int           cyc = 0;
  int           m_pending;
  logic [P-1:0] m_req, m_prev_s, m_prev_c, m_pulse;
  int           m_decide_at;
  bit           m_after_gap;
  int           m_coin_from  = -1000;
  int           m_start_from = -1000;
  logic [P*4-1:0]  exp_dirs;
  logic [P*NB-1:0] exp_fire;
  logic [P-1:0]    exp_start;
  logic            exp_coin;
  logic [2:0]      exp_pending;

  always @(posedge clk_sys) begin
    logic [JW-1:0] w, orw;
    logic [P-1:0]  sv, se, ce, nreq;
    logic          u, dn, l, r;
    int            e, d, idx;
    cyc++;
    if (reset) begin
      m_pending = 0; m_req = '0; m_prev_s = '1; m_prev_c = '1; m_pulse = '0;
      m_decide_at = cyc + 1; m_after_gap = 0;
      m_coin_from = -1000; m_start_from = -1000;
      exp_dirs = '0; exp_fire = '0; exp_start = '0; exp_coin = 0; exp_pending = 0;
    end else begin
      orw = '0;
      for (int k = 0; k < P; k++) orw = orw | joy_in[k*JW +: JW];
      for (int k = 0; k < P; k++) begin
        w = merge ? orw : joy_in[k*JW +: JW];
        u = w[3]; dn = w[2]; l = w[1]; r = w[0];
        if (u && dn) begin u = 0; dn = 0; end
        if (l && r) begin l = 0; r = 0; end
        exp_dirs[k*4 +: 4] = {u, dn, l, r};
        exp_fire[k*NB +: NB] = w[4 +: NB];
        idx = SB + k;
        if (merge) sv[k] = (idx < JW) ? orw[idx] : 1'b0;
        else sv[k] = w[SB];
      end
      se = auto_coin ? (sv & ~m_prev_s) : '0;
      ce = coin_btn & ~m_prev_c;
      m_prev_s = sv; m_prev_c = coin_btn;
      e = $countones(se) + $countones(ce);
      d = 0;
      nreq = m_req | se;
      if (cyc >= m_decide_at) begin
        if (m_pending > 0) begin
          d = 1; m_coin_from = cyc; m_decide_at = cyc + CP + CG; m_after_gap = 1;
        end else if (m_after_gap && m_req != '0) begin
          m_start_from = cyc; m_pulse = m_req; nreq = se;
          m_decide_at = cyc + SP + 1; m_after_gap = 0;
        end else begin
          m_decide_at = cyc + 1; m_after_gap = 0;
        end
      end
      m_req = nreq;
      m_pending = m_pending + e - d;
      if (m_pending > 7) m_pending = 7;
      exp_pending = 3'(m_pending);
      exp_coin = (cyc >= m_coin_from) && (cyc < m_coin_from + CP);
      if (cyc >= m_start_from && cyc < m_start_from + SP) exp_start = m_pulse;
      else exp_start = auto_coin ? '0 : sv;
    end
  end

  task automatic test_reset();
    reset = 1; joy_in = '0; merge = 0; auto_coin = 0; coin_btn = '0;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if ({dirs_out, fire_out, start_out, coin_out} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", {dirs_out, fire_out, start_out, coin_out});
    end
    n_checks++;
    if (pending !== 3'd0) begin
      n_err++; $display("FAIL reset_pending: got %0d expected 0", pending);
    end
    reset = 0;
    @(negedge clk_sys);
  endtask

  task automatic test_dirs();
    merge = 1; joy_in = {16'h0008, 16'h0000};
    @(negedge clk_sys);
    n_checks++;
    if (dirs_out !== 8'b1000_1000) begin
      n_err++; $display("FAIL merged_up: got %b expected 10001000", dirs_out);
    end
    merge = 0;
    @(negedge clk_sys);
    n_checks++;
    if (dirs_out !== 8'b1000_0000) begin
      n_err++; $display("FAIL separate_up: got %b expected 10000000", dirs_out);
    end
    merge = 1; joy_in = {16'h0000, 16'h000C};
    @(negedge clk_sys);
    n_checks++;
    if (dirs_out !== 8'b0000_0000) begin
      n_err++; $display("FAIL socd_updown: got %b expected 00000000", dirs_out);
    end
    joy_in = {16'h0000, 16'h0002};
    @(negedge clk_sys);
    n_checks++;
    if (dirs_out !== 8'b0010_0010) begin
      n_err++; $display("FAIL left_only: got %b expected 00100010", dirs_out);
    end
    merge = 0; joy_in = {16'h0000, 16'h0010};
    @(negedge clk_sys);
    n_checks++;
    if (fire_out !== 2'b01) begin
      n_err++; $display("FAIL fire_sep: got %b expected 01", fire_out);
    end
    for (int i = 0; i < 200; i++) begin
      joy_in = P*JW'({$urandom, $urandom});
      merge  = 1'($urandom);
      @(negedge clk_sys);
      n_checks++;
      if (dirs_out !== exp_dirs || fire_out !== exp_fire || start_out !== exp_start) begin
        n_err++;
        $display("FAIL rand_map: got d=%b f=%b s=%b expected d=%b f=%b s=%b",
                 dirs_out, fire_out, start_out, exp_dirs, exp_fire, exp_start);
      end
    end
    joy_in = '0; merge = 0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_single_start();
    logic       ec;
    logic [1:0] es;
    int         hi = 0;
    auto_coin = 1;
    @(negedge clk_sys);
    joy_in[SB] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_sys);
      if (i == 2) joy_in[SB] = 1'b0;
      ec = (i >= 1 && i <= 4);
      es = (i == 8 || i == 9) ? 2'b01 : 2'b00;
      if (coin_out) hi++;
      n_checks++;
      if (coin_out !== ec || start_out !== es) begin
        n_err++; $display("FAIL single_timeline i=%0d: got c=%b s=%b expected c=%b s=%b", i, coin_out, start_out, ec, es);
      end
      n_checks++;
      if (pending !== exp_pending || coin_out !== exp_coin || start_out !== exp_start) begin
        n_err++; $display("FAIL single_model i=%0d: got p=%0d expected p=%0d", i, pending, exp_pending);
      end
      if (i <= 1) begin
        n_checks++;
        if (pending !== ((i == 0) ? 3'd1 : 3'd0)) begin
          n_err++; $display("FAIL single_pending i=%0d: got %0d expected %0d", i, pending, (i == 0) ? 1 : 0);
        end
      end
    end
    n_checks++;
    if (hi != CP) begin
      n_err++; $display("FAIL single_coin_len: got %0d expected %0d", hi, CP);
    end
  endtask

  task automatic test_dual_start();
    logic       ec;
    logic [1:0] es;
    logic [2:0] ep;
    joy_in[SB] = 1'b1; joy_in[JW+SB] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_sys);
      if (i == 3) begin joy_in[SB] = 1'b0; joy_in[JW+SB] = 1'b0; end
      ec = (i >= 1 && i <= 4) || (i >= 8 && i <= 11);
      es = (i == 15 || i == 16) ? 2'b11 : 2'b00;
      ep = (i == 0) ? 3'd2 : (i <= 7) ? 3'd1 : 3'd0;
      n_checks++;
      if (coin_out !== ec || start_out !== es || pending !== ep) begin
        n_err++; $display("FAIL dual_timeline i=%0d: got c=%b s=%b p=%0d expected c=%b s=%b p=%0d",
                          i, coin_out, start_out, pending, ec, es, ep);
      end
    end
  endtask

  task automatic test_saturation();
    int   pulses = 0;
    int   maxp = 0;
    logic last = 0;
    for (int i = 0; i < 75; i++) begin
      coin_btn = (i <= 10) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      @(negedge clk_sys);
      if (coin_out && !last) pulses++;
      last = coin_out;
      if (int'(pending) > maxp) maxp = int'(pending);
      n_checks++;
      if (pending !== exp_pending || coin_out !== exp_coin) begin
        n_err++; $display("FAIL sat_model i=%0d: got p=%0d c=%b expected p=%0d c=%b", i, pending, coin_out, exp_pending, exp_coin);
      end
      if (i == 10) begin
        n_checks++;
        if (pending !== 3'd7) begin
          n_err++; $display("FAIL sat_level: got %0d expected 7", pending);
        end
      end
    end
    n_checks++;
    if (pulses != 9 || maxp != 7) begin
      n_err++; $display("FAIL sat_pulses: got pulses=%0d max=%0d expected pulses=9 max=7", pulses, maxp);
    end
  endtask

  task automatic test_reset_mid();
    coin_btn = 2'b11; @(negedge clk_sys);
    coin_btn = 2'b00; @(negedge clk_sys);
    coin_btn = 2'b11; @(negedge clk_sys);
    n_checks++;
    if (pending !== 3'd3 || coin_out !== 1'b1) begin
      n_err++; $display("FAIL mid_setup: got p=%0d c=%b expected p=3 c=1", pending, coin_out);
    end
    coin_btn = 2'b00; reset = 1; joy_in[SB] = 1'b1;
    @(negedge clk_sys);
    n_checks++;
    if (coin_out !== 1'b0 || pending !== 3'd0 || start_out !== 2'b00) begin
      n_err++; $display("FAIL mid_reset: got c=%b p=%0d s=%b expected c=0 p=0 s=00", coin_out, pending, start_out);
    end
    @(negedge clk_sys);
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (coin_out !== 1'b0 || pending !== 3'd0) begin
        n_err++; $display("FAIL held_start i=%0d: got c=%b p=%0d expected c=0 p=0", i, coin_out, pending);
      end
    end
    joy_in[SB] = 1'b0; @(negedge clk_sys);
    joy_in[SB] = 1'b1; @(negedge clk_sys);
    n_checks++;
    if (pending !== 3'd1) begin
      n_err++; $display("FAIL repress: got %0d expected 1", pending);
    end
    joy_in[SB] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      n_checks++;
      if (pending !== exp_pending || coin_out !== exp_coin || start_out !== exp_start) begin
        n_err++; $display("FAIL repress_seq i=%0d: got p=%0d c=%b s=%b expected p=%0d c=%b s=%b",
                          i, pending, coin_out, start_out, exp_pending, exp_coin, exp_start);
      end
    end
  endtask

  task automatic test_random();
    logic [JW-1:0] w;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < P; k++) begin
        w = JW'($urandom);
        w[7:5] = ($urandom_range(15) == 0) ? 3'($urandom) : joy_in[k*JW+5 +: 3];
        joy_in[k*JW +: JW] = w;
      end
      if ($urandom_range(63) == 0) merge = ~merge;
      if ($urandom_range(99) == 0) auto_coin = ~auto_coin;
      coin_btn = ($urandom_range(11) == 0) ? P'($urandom) : coin_btn;
      reset = ($urandom_range(399) == 0);
      @(negedge clk_sys);
      n_checks++;
      if (dirs_out !== exp_dirs || fire_out !== exp_fire || start_out !== exp_start ||
          coin_out !== exp_coin || pending !== exp_pending) begin
        n_err++;
        $display("FAIL random i=%0d: got d=%b f=%b s=%b c=%b p=%0d expected d=%b f=%b s=%b c=%b p=%0d",
                 i, dirs_out, fire_out, start_out, coin_out, pending,
                 exp_dirs, exp_fire, exp_start, exp_coin, exp_pending);
      end
    end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_dirs();
    test_single_start();
    test_dual_start();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
